// File: rtl/frame_collision_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_collision_monitor_pkg
// Brief    : Shared game constants, FSM state encoding and output-flag decode.
// Revision : 1.0 - initial release
// ============================================================================
package frame_collision_monitor_pkg;

    localparam int NUM_BLOCKS            = 16;
    localparam int LIVES_INIT_DEFAULT    = 3;
    localparam int INVULN_FRAMES_DEFAULT = 60;

    typedef enum logic [2:0] {
        RESET_LVL  = 3'd0,
        PLAY       = 3'd1,
        INVULN     = 3'd2,
        LEVEL_DONE = 3'd3,
        GAME_OVER  = 3'd4
    } state_t;

    // Packed as {levelRst, hitFlash, levelDone, gameOver}
    function automatic logic [3:0] stateFlags(state_t s);
        logic [3:0] f;
        f = 4'b0000;
        case (s)
            RESET_LVL:  f = 4'b1000;
            INVULN:     f = 4'b0100;
            LEVEL_DONE: f = 4'b0010;
            GAME_OVER:  f = 4'b0001;
            default:    f = 4'b0000;
        endcase
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_collision_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_collision_monitor_if
// Brief    : Pixel-stream inputs and game status outputs of the collision monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface frame_collision_monitor_if #(
    parameter int NUM_BLOCKS = 16
);
    logic                  update;
    logic [NUM_BLOCKS-1:0] blocks;
    logic                  player;
    logic                  goal;
    logic                  start;
    logic                  level_rst;
    logic [1:0]            lives;
    logic                  hit_flash;
    logic                  level_done;
    logic                  game_over;
    logic [NUM_BLOCKS-1:0] hit_mask;

    modport master (
        output update, blocks, player, goal, start,
        input  level_rst, lives, hit_flash, level_done, game_over, hit_mask
    );

    modport slave (
        input  update, blocks, player, goal, start,
        output level_rst, lives, hit_flash, level_done, game_over, hit_mask
    );
endinterface
`default_nettype wire

// File: rtl/frame_collision_monitor_button_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : button_sync_edge
// Brief    : Two-flop synchroniser for an asynchronous button plus rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module button_sync_edge (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_btn,
    output logic      o_pulse
);
    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_pulse = r_sync2 & ~r_prev;
endmodule
`default_nettype wire

// File: rtl/frame_collision_monitor.sv
`default_nettype none
// ============================================================================
// Module   : frame_collision_monitor
// Brief    : Per-frame player/obstacle/goal overlap accumulation and game FSM.
// Revision : 1.0 - initial release
// ============================================================================
module frame_collision_monitor
    import frame_collision_monitor_pkg::*;
#(
    parameter int NUM_BLOCKS    = frame_collision_monitor_pkg::NUM_BLOCKS,
    parameter int LIVES_INIT    = frame_collision_monitor_pkg::LIVES_INIT_DEFAULT,
    parameter int INVULN_FRAMES = frame_collision_monitor_pkg::INVULN_FRAMES_DEFAULT
) (
    input wire logic                clk,
    input wire logic                rst,
    frame_collision_monitor_if.slave bus
);
    state_t                r_state;
    logic                  r_updateQ;
    logic                  r_hitAcc;
    logic                  r_goalAcc;
    logic [NUM_BLOCKS-1:0] r_maskAcc;
    logic [NUM_BLOCKS-1:0] r_hitMask;
    logic [7:0]            r_timer;
    logic [1:0]            r_lives;
    logic                  r_levelRst;
    logic                  r_hitFlash;
    logic                  r_levelDone;
    logic                  r_gameOver;

    logic                  w_updateEdge;
    logic                  w_startEdge;
    logic                  w_hitClose;
    logic                  w_goalClose;
    logic [NUM_BLOCKS-1:0] w_maskTerm;
    logic [NUM_BLOCKS-1:0] w_maskClose;

    button_sync_edge u_startSync (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (bus.start),
        .o_pulse (w_startEdge)
    );

    // The edge-cycle pixel is folded in so it counts toward the closing frame
    always_comb begin
        w_updateEdge = bus.update & ~r_updateQ;
        w_maskTerm   = bus.blocks & {NUM_BLOCKS{bus.player}};
        w_hitClose   = r_hitAcc  | (bus.player & (|bus.blocks));
        w_goalClose  = r_goalAcc | (bus.player & bus.goal);
        w_maskClose  = r_maskAcc | w_maskTerm;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RESET_LVL;
            r_updateQ   <= 1'b0;
            r_hitAcc    <= 1'b0;
            r_goalAcc   <= 1'b0;
            r_maskAcc   <= '0;
            r_hitMask   <= '0;
            r_timer     <= 8'd0;
            r_lives     <= 2'(LIVES_INIT);
            {r_levelRst, r_hitFlash, r_levelDone, r_gameOver} <= stateFlags(RESET_LVL);
        end else begin
            r_updateQ <= bus.update;

            if (w_updateEdge) begin
                r_hitAcc  <= 1'b0;
                r_goalAcc <= 1'b0;
                r_maskAcc <= '0;
            end else if (r_state == PLAY) begin
                r_hitAcc  <= w_hitClose;
                r_goalAcc <= w_goalClose;
                r_maskAcc <= w_maskClose;
            end

            case (r_state)
                RESET_LVL: begin
                    if (w_updateEdge) begin
                        r_state <= PLAY;
                        {r_levelRst, r_hitFlash, r_levelDone, r_gameOver} <= stateFlags(PLAY);
                    end
                end
                PLAY: begin
                    if (w_updateEdge && w_hitClose) begin
                        r_hitMask <= w_maskClose;
                        if (r_lives <= 2'd1) begin
                            r_lives <= 2'd0;
                            r_state <= GAME_OVER;
                            {r_levelRst, r_hitFlash, r_levelDone, r_gameOver} <= stateFlags(GAME_OVER);
                        end else begin
                            r_lives <= r_lives - 2'd1;
                            r_timer <= 8'(INVULN_FRAMES);
                            r_state <= INVULN;
                            {r_levelRst, r_hitFlash, r_levelDone, r_gameOver} <= stateFlags(INVULN);
                        end
                    end else if (w_updateEdge && w_goalClose) begin
                        r_state <= LEVEL_DONE;
                        {r_levelRst, r_hitFlash, r_levelDone, r_gameOver} <= stateFlags(LEVEL_DONE);
                    end
                end
                INVULN: begin
                    if (w_updateEdge) begin
                        if (r_timer != 8'd0) begin
                            r_timer <= r_timer - 8'd1;
                        end
                        if (r_timer <= 8'd1) begin
                            r_state <= PLAY;
                            {r_levelRst, r_hitFlash, r_levelDone, r_gameOver} <= stateFlags(PLAY);
                        end
                    end
                end
                LEVEL_DONE: begin
                    if (w_startEdge) begin
                        r_state <= RESET_LVL;
                        {r_levelRst, r_hitFlash, r_levelDone, r_gameOver} <= stateFlags(RESET_LVL);
                    end
                end
                GAME_OVER: begin
                    if (w_startEdge) begin
                        r_lives <= 2'(LIVES_INIT);
                        r_state <= RESET_LVL;
                        {r_levelRst, r_hitFlash, r_levelDone, r_gameOver} <= stateFlags(RESET_LVL);
                    end
                end
                default: begin
                    r_state <= RESET_LVL;
                    {r_levelRst, r_hitFlash, r_levelDone, r_gameOver} <= stateFlags(RESET_LVL);
                end
            endcase
        end
    end

    assign bus.level_rst  = r_levelRst;
    assign bus.lives      = r_lives;
    assign bus.hit_flash  = r_hitFlash;
    assign bus.level_done = r_levelDone;
    assign bus.game_over  = r_gameOver;
    assign bus.hit_mask   = r_hitMask;
endmodule
`default_nettype wire

// File: tb/tb_frame_collision_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_collision_monitor
// Brief    : Directed self-checking bench for the frame collision monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_collision_monitor;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    frame_collision_monitor_if #(.NUM_BLOCKS(16)) bus ();

    frame_collision_monitor #(
        .NUM_BLOCKS    (16),
        .LIVES_INIT    (3),
        .INVULN_FRAMES (60)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idleInputs();
        bus.update = 1'b0;
        bus.blocks = 16'h0000;
        bus.player = 1'b0;
        bus.goal   = 1'b0;
    endtask

    // One-cycle pixel stimulus mid-frame
    task automatic pixel(input logic [15:0] b, input logic p, input logic g);
        @(negedge clk);
        bus.blocks = b;
        bus.player = p;
        bus.goal   = g;
        @(negedge clk);
        idleInputs();
    endtask

    task automatic pulseUpdate();
        @(negedge clk);
        bus.update = 1'b1;
        @(negedge clk);
        bus.update = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idleInputs();
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.level_rst !== 1'b1) begin errors++; $display("FAIL reset_level_rst got %0b exp 1", bus.level_rst); end
        checks++;
        if (bus.lives !== 2'd3) begin errors++; $display("FAIL reset_lives got %0d exp 3", bus.lives); end
        checks++;
        if ({bus.hit_flash, bus.level_done, bus.game_over} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %03b exp 000", {bus.hit_flash, bus.level_done, bus.game_over});
        end
        checks++;
        if (bus.hit_mask !== 16'h0000) begin errors++; $display("FAIL reset_hit_mask got %04h exp 0000", bus.hit_mask); end
        repeat (100) @(negedge clk);
        checks++;
        if (bus.level_rst !== 1'b1 || bus.lives !== 2'd3) begin
            errors++; $display("FAIL hold_reset_lvl got rst=%0b lives=%0d exp rst=1 lives=3", bus.level_rst, bus.lives);
        end
        pulseUpdate();
        checks++;
        if (bus.level_rst !== 1'b0) begin errors++; $display("FAIL enter_play_level_rst got %0b exp 0", bus.level_rst); end
    endtask

    task automatic test_play_no_hit();
        pixel(16'h0000, 1'b1, 1'b0);
        pixel(16'hFFFF, 1'b0, 1'b1);
        pulseUpdate();
        checks++;
        if ({bus.lives, bus.hit_flash, bus.level_done, bus.game_over} !== {2'd3, 3'b000}) begin
            errors++; $display("FAIL no_overlap got lives=%0d flags=%03b exp lives=3 flags=000",
                               bus.lives, {bus.hit_flash, bus.level_done, bus.game_over});
        end
    endtask

    task automatic test_hit();
        pixel(16'h0020, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        pulseUpdate();
        checks++;
        if (bus.lives !== 2'd2) begin errors++; $display("FAIL hit_lives got %0d exp 2", bus.lives); end
        checks++;
        if (bus.hit_flash !== 1'b1) begin errors++; $display("FAIL hit_flash got %0b exp 1", bus.hit_flash); end
        checks++;
        if (bus.hit_mask !== 16'h0020) begin errors++; $display("FAIL hit_mask got %04h exp 0020", bus.hit_mask); end
    endtask

    task automatic test_invuln();
        for (int i = 0; i < 59; i++) begin
            pixel(16'hFFFF, 1'b1, 1'b0);
            pulseUpdate();
        end
        checks++;
        if ({bus.hit_flash, bus.lives, bus.hit_mask} !== {1'b1, 2'd2, 16'h0020}) begin
            errors++; $display("FAIL invuln_59 got flash=%0b lives=%0d mask=%04h exp flash=1 lives=2 mask=0020",
                               bus.hit_flash, bus.lives, bus.hit_mask);
        end
        pulseUpdate();
        checks++;
        if ({bus.hit_flash, bus.lives} !== {1'b0, 2'd2}) begin
            errors++; $display("FAIL invuln_end got flash=%0b lives=%0d exp flash=0 lives=2", bus.hit_flash, bus.lives);
        end
    endtask

    task automatic test_level_done();
        // Goal pixel lands on the update edge cycle itself
        @(negedge clk);
        bus.update = 1'b1;
        bus.player = 1'b1;
        bus.goal   = 1'b1;
        @(negedge clk);
        idleInputs();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.level_done, bus.game_over, bus.hit_flash, bus.lives} !== {3'b100, 2'd2}) begin
            errors++; $display("FAIL level_done got done=%0b over=%0b flash=%0b lives=%0d exp 1 0 0 2",
                               bus.level_done, bus.game_over, bus.hit_flash, bus.lives);
        end
        bus.start = 1'b1;
        repeat (5) @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.level_done, bus.level_rst, bus.lives} !== {2'b01, 2'd2}) begin
            errors++; $display("FAIL level_restart got done=%0b lrst=%0b lives=%0d exp 0 1 2",
                               bus.level_done, bus.level_rst, bus.lives);
        end
        pulseUpdate();
        checks++;
        if (bus.level_rst !== 1'b0) begin errors++; $display("FAIL replay_level_rst got %0b exp 0", bus.level_rst); end
    endtask

    task automatic test_hit_priority();
        pixel(16'h0001, 1'b1, 1'b0);
        pulseUpdate();
        checks++;
        if ({bus.lives, bus.hit_mask} !== {2'd1, 16'h0001}) begin
            errors++; $display("FAIL second_hit got lives=%0d mask=%04h exp 1 0001", bus.lives, bus.hit_mask);
        end
        repeat (60) pulseUpdate();
        pixel(16'h0000, 1'b1, 1'b1);
        pixel(16'h0008, 1'b1, 1'b0);
        pulseUpdate();
        checks++;
        if ({bus.lives, bus.game_over, bus.level_done, bus.hit_flash} !== {2'd0, 3'b100}) begin
            errors++; $display("FAIL hit_priority got lives=%0d over=%0b done=%0b flash=%0b exp 0 1 0 0",
                               bus.lives, bus.game_over, bus.level_done, bus.hit_flash);
        end
        checks++;
        if (bus.hit_mask !== 16'h0008) begin errors++; $display("FAIL priority_mask got %04h exp 0008", bus.hit_mask); end
        // Start edge reaches the FSM on the same cycle as an update edge
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.update = 1'b1;
        @(negedge clk);
        bus.update = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({bus.lives, bus.level_rst, bus.game_over} !== {2'd3, 2'b10}) begin
            errors++; $display("FAIL restart got lives=%0d lrst=%0b over=%0b exp 3 1 0",
                               bus.lives, bus.level_rst, bus.game_over);
        end
        bus.start = 1'b1;
        repeat (5) @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.level_rst, bus.hit_mask} !== {1'b1, 16'h0008}) begin
            errors++; $display("FAIL start_ignored got lrst=%0b mask=%04h exp 1 0008", bus.level_rst, bus.hit_mask);
        end
    endtask

    task automatic test_async_reset();
        pulseUpdate();
        pixel(16'h0040, 1'b1, 1'b0);
        pulseUpdate();
        repeat (30) pulseUpdate();
        checks++;
        if ({bus.hit_flash, bus.lives, bus.hit_mask} !== {1'b1, 2'd2, 16'h0040}) begin
            errors++; $display("FAIL pre_reset got flash=%0b lives=%0d mask=%04h exp 1 2 0040",
                               bus.hit_flash, bus.lives, bus.hit_mask);
        end
        @(negedge clk);
        bus.player = 1'b1;
        bus.blocks = 16'h0100;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.level_rst, bus.lives, bus.hit_flash, bus.hit_mask} !== {1'b1, 2'd3, 1'b0, 16'h0000}) begin
            errors++; $display("FAIL async_reset got lrst=%0b lives=%0d flash=%0b mask=%04h exp 1 3 0 0000",
                               bus.level_rst, bus.lives, bus.hit_flash, bus.hit_mask);
        end
        @(negedge clk);
        rst = 1'b0;
        idleInputs();
        pulseUpdate();
        pulseUpdate();
        checks++;
        if ({bus.lives, bus.level_rst, bus.hit_flash} !== {2'd3, 2'b00}) begin
            errors++; $display("FAIL post_reset_play got lives=%0d lrst=%0b flash=%0b exp 3 0 0",
                               bus.lives, bus.level_rst, bus.hit_flash);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_play_no_hit();
        test_hit();
        test_invuln();
        test_level_done();
        test_hit_priority();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/frame_collision_monitor.md
Name: frame_collision_monitor

Overview:
- Sits directly downstream of the level block generator. Consumes its per-pixel `blocks[15:0]` hit flags together with the player and goal sprite pixel flags.
- Accumulates overlaps over each video frame and decides hit / level-complete / game-over at the frame tick.
- Drives the level-reset request back into the generator and exposes lives and status to the renderer and HUD.

Parameters:
- NUM_BLOCKS, 16, width of the blocks bus.
- LIVES_INIT, 3, lives loaded at power-up and on restart (1..3).
- INVULN_FRAMES, 60, frames of post-hit immunity (1..255).

Ports:
- clk  in  1  pixel clock, same domain as the xCount/yCount counters.
- rst  in  1  asynchronous, active-high reset.
- update  in  1  frame tick level signal. Rising edge detected on clk; one cycle = update_edge.
- blocks  in  NUM_BLOCKS  per-pixel obstacle flags, registered one cycle after xCount/yCount.
- player  in  1  player sprite pixel flag, aligned to the same cycle as blocks.
- goal  in  1  goal tile pixel flag, aligned to the same cycle as blocks.
- start  in  1  raw pushbutton. Asynchronous; 2-flop synchronised internally, rising edge used.
- level_rst  out  1  held high to reset the obstacle generator; must span at least one update rising edge.
- lives  out  2  remaining lives.
- hit_flash  out  1  high while invulnerable.
- level_done  out  1  high in LEVEL_DONE.
- game_over  out  1  high in GAME_OVER.
- hit_mask  out  NUM_BLOCKS  blocks touched in the last frame that caused a hit; held until the next hit.

Behaviour:
- Reset values:
  - state = RESET_LVL, level_rst = 1, lives = LIVES_INIT.
  - hit_flash = 0, level_done = 0, game_over = 0, hit_mask = 0.
  - All accumulators = 0, invuln timer = 0, update/start edge registers = 0.
- Edge detection:
  - update_edge = update & ~update_q.
  - start_edge is taken on the synchronised start signal; 3-cycle latency from pin.
- Per-cycle accumulation, only in PLAY:
  - hit_acc |= player & (|blocks).
  - goal_acc |= player & goal.
  - mask_acc |= blocks & {NUM_BLOCKS{player}}.
- Frame decision on the update_edge cycle:
  - Uses acc OR the current-cycle term, so a pixel on the edge cycle belongs to the closing frame.
  - Accumulators then clear in every state.
- FSM transitions:
  - RESET_LVL: level_rst = 1. On update_edge, go to PLAY. Because level_rst is still 1 on that edge, the generator samples it.
  - PLAY, hit (takes priority over goal when both occur in one frame):
    - hit_mask <= closing mask.
    - If lives == 1: lives <= 0, go to GAME_OVER.
    - Otherwise: lives <= lives-1, timer <= INVULN_FRAMES, go to INVULN.
  - PLAY, goal only: go to LEVEL_DONE.
  - PLAY, neither: stay.
  - INVULN: hit_flash = 1; no accumulation.
    - On update_edge: timer decrements.
    - When the timer reaches 0 on an edge, go to PLAY; accumulation resumes the following frame.
    - Obstacles are not reset.
  - LEVEL_DONE: level_done = 1. On start_edge, go to RESET_LVL; lives kept.
  - GAME_OVER: game_over = 1. On start_edge, lives <= LIVES_INIT and go to RESET_LVL.
- Arithmetic and width rules:
  - lives never underflows; a decrement is only issued when lives ≥ 1.
  - Timer is 8 bits and is not decremented below 0.
- Simultaneous events:
  - start_edge is ignored outside LEVEL_DONE and GAME_OVER.
  - update_edge together with start_edge in GAME_OVER: start wins, go to RESET_LVL. The update edge is not counted for leaving RESET_LVL; the next edge is needed.
- Reset mid-operation: asynchronous rst immediately forces all reset values regardless of state, including mid-frame with partial accumulators.
- Outputs are registered; state-derived outputs change the cycle after the transition.

Decomposition:
- Shared game package holds:
  - State encoding: RESET_LVL, PLAY, INVULN, LEVEL_DONE, GAME_OVER (3-bit).
  - LIVES_INIT and INVULN_FRAMES defaults.
  - NUM_BLOCKS = 16, shared with the level generators.
- One natural sub-module: button_sync_edge, the 2-flop synchroniser plus rising-edge pulse for start. It is reused by later levels' controls.

Test Plan:
- Reset, then hold update low for 100 cycles, then one update rising edge:
  - level_rst = 1 and lives = 3 until the edge.
  - state PLAY and level_rst = 0 the cycle after the edge.
- In PLAY, assert player = 1 with blocks = 16'h0020 for one cycle mid-frame, then update edge:
  - lives = 2, hit_flash = 1, hit_mask = 16'h0020.
  - After 60 further update edges: hit_flash = 0.
- During INVULN, overlap player with blocks every frame: lives stays 2 and hit_mask is unchanged.
- player & goal and player & blocks[3] in the same frame, with lives = 1:
  - Hit wins: lives = 0, game_over = 1, level_done = 0.
  - Then pulse start for 5 cycles: lives = 3, level_rst = 1.
- player & goal only in a frame: level_done = 1 after the edge; start keeps lives unchanged and returns to RESET_LVL.
- Assert rst asynchronously mid-frame in INVULN with timer = 30: outputs immediately return to reset values without waiting for a clk edge.
